pad_bus_ctrl: RTL and testbench
===============================

Name: pad_bus_ctrl

Overview:
- Registered driver/receiver controller for a WIDTH-bit bidirectional pad bus.
- Sits directly upstream of one bidirectional I/O buffer per bit: drives each buffer's data input (pad_i) and tristate control (pad_t, 1 = high-Z), and samples each buffer's output (pad_o).
- Converts a valid/ready transmit stream into driven bus bursts with a guaranteed release/turnaround period.
- Captures bus data only while the bus is released.

Parameters:
- WIDTH, 8, bus width in bits.
- TURN_CYCLES, 1, high-Z cycles enforced after each burst before the next drive; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- tx_valid  input  1  transmit beat valid.
- tx_data  input  WIDTH  transmit beat data.
- tx_last  input  1  marks final beat of a burst.
- tx_ready  output  1  beat accepted when tx_valid & tx_ready at a rising edge.
- rx_en  input  1  request to sample the bus this cycle.
- rx_valid  output  1  one-cycle pulse, rx_data updated.
- rx_data  output  WIDTH  captured bus value.
- pad_o  input  WIDTH  from buffer O (bus value).
- pad_i  output  WIDTH  to buffer I.
- pad_t  output  WIDTH  to buffer T; all bits equal; 1 = high-Z.
- busy  output  1  state != IDLE.
- contention_err  output  1  sticky drive-mismatch flag (see Optional Feature).

Behaviour:
Clocking and reset:
- Single clock; all outputs registered except tx_ready and busy, which decode state.
- Synchronous active-high reset, effective at the next rising edge with rst=1:
  - state=IDLE; pad_t=all 1; pad_i=0; rx_valid=0; rx_data=0; contention_err=0; turn counter=0.
- Reset mid-burst: bus is released at that edge; the in-flight beat is dropped and no TURN period is served.

States:
- IDLE
  - pad_t=1, tx_ready=1.
  - Beat accepted without tx_last: pad_i<=tx_data, pad_t<=0, go to DRIVE.
  - Beat accepted with tx_last: pad_i<=tx_data, pad_t<=0, go to LAST.
- DRIVE
  - pad_t=0, tx_ready=1.
  - Beat accepted: pad_i<=tx_data, next state DRIVE, or LAST if tx_last=1.
  - No beat: pad_i holds its value and the bus keeps being driven (parked).
- LAST
  - Exactly one cycle with the final beat on the bus; tx_ready=0.
  - At the next edge: pad_t<=1, go to TURN (count loaded with TURN_CYCLES), or to IDLE if TURN_CYCLES=0.
- TURN
  - pad_t=1, tx_ready=0.
  - Counter decrements each cycle; go to IDLE when count reaches 1.
  - Net effect: exactly TURN_CYCLES high-Z cycles between the last drive cycle and the first cycle in which IDLE can accept a beat.

Timing:
- Latency from beat acceptance (edge k) to the beat appearing on the bus: 1 cycle (driven throughout cycle k+1).
- Back-to-back beats: one per cycle, no bubbles.

Receive path:
- At an edge with rx_en=1 and the registered pad_t=1 (IDLE or TURN): rx_data<=pad_o and rx_valid<=1 for one cycle.
- Otherwise rx_valid<=0.
- rx_en while pad_t=0 is ignored: no capture, rx_data holds.

Simultaneous events:
- tx_valid during LAST or TURN is not accepted; the upstream source must hold the beat.
- rx_en and a beat accepted in the same IDLE cycle: both take effect; the capture uses the pre-drive bus value.

Optional Feature:
Macro: PAD_BUS_CONTENTION_CHK_EN
- Defined:
  - Every edge where the registered pad_t=0, compare pad_o to pad_i.
  - Any mismatch sets contention_err=1; it stays 1 until rst.
  - Catches another driver or a stuck pin while this block is driving.
- Undefined:
  - No comparator is built.
  - contention_err is tied to 0.

Test Plan:
1. Reset then idle, rx_en=0 → pad_t=0xFF, pad_i=0x00, rx_valid=0, busy=0, tx_ready=1.
2. Burst 0x11, 0x22, 0x33 (last) on consecutive cycles, TURN_CYCLES=1 → pad_i shows 0x11/0x22/0x33 on the three cycles after each acceptance with pad_t=0x00; then pad_t=0xFF for one TURN cycle; tx_ready=0 during LAST and TURN, then 1 again.
3. Gap in burst: 0xA5, tx_valid low for 3 cycles, then 0x5A (last) → bus parked at 0xA5 with pad_t=0 during the gap, then 0x5A for one cycle, then release.
4. TURN_CYCLES=3, tx_valid held high after the last beat → next beat accepted exactly 3 high-Z cycles after release.
5. rx_en=1 in IDLE with pad_o=0xC3 → rx_valid pulses with rx_data=0xC3; rx_en=1 while driving → rx_valid stays 0 and rx_data stays 0xC3.
6. Macro defined, drive 0x0F with pad_o forced to 0x0E → contention_err=1 and stays 1 after release, until rst; rst mid-burst → pad_t=0xFF on the next edge.

Source files
------------

// File: rtl/pad_bus_ctrl.sv
// pad_bus_ctrl: registered stream-to-pad-bus driver with turnaround and release-time capture; PAD_BUS_CONTENTION_CHK_EN adds a sticky drive-mismatch check.
module pad_bus_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_last,
  output logic             tx_ready,
  input  logic             rx_en,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  input  logic [WIDTH-1:0] pad_o,
  output logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_t,
  output logic             busy,
  output logic             contention_err
);
  typedef enum logic [1:0] {IDLE, DRIVE, LAST, TURN} state_e;
  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             pad_t_q, pad_t_d;
  logic [WIDTH-1:0] pad_i_q, pad_i_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             err_q, err_d;
  logic             acc;
  assign tx_ready = state_q == IDLE || state_q == DRIVE;
  assign busy     = state_q != IDLE;
  assign acc      = tx_valid & tx_ready;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DRIVE: state_d = acc ? (tx_last ? LAST : DRIVE) : state_q;
      LAST: begin
        state_d = TURN_CYCLES == 0 ? IDLE : TURN;
        cnt_d   = 4'(TURN_CYCLES);
      end
      default: begin
        state_d = cnt_q == 4'd1 ? IDLE : TURN;
        cnt_d   = cnt_q - 4'd1;
      end
    endcase
    // the tristate register follows the state we are about to enter, so the bus is driven exactly in DRIVE/LAST
    pad_t_d    = !(state_d == DRIVE || state_d == LAST);
    pad_i_d    = acc ? tx_data : pad_i_q;
    rx_valid_d = rx_en & pad_t_q;
    rx_data_d  = rx_valid_d ? pad_o : rx_data_q;
`ifdef PAD_BUS_CONTENTION_CHK_EN
    err_d      = err_q | (!pad_t_q && pad_o != pad_i_q);
`else
    err_d      = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pad_t_q    <= 1'b1;
      pad_i_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pad_t_q    <= pad_t_d;
      pad_i_q    <= pad_i_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      err_q      <= err_d;
    end
  end
  assign pad_t          = {WIDTH{pad_t_q}};
  assign pad_i          = pad_i_q;
  assign rx_valid       = rx_valid_q;
  assign rx_data        = rx_data_q;
  assign contention_err = err_q;
endmodule

// File: tb/tb_pad_bus_ctrl.sv
// tb_pad_bus_ctrl: directed vector table plus hand sequences for turnaround, contention and reset corners.
module tb_pad_bus_ctrl;
  logic       clk = 0, rst = 1, tx_valid = 0, tx_last = 0, rx_en = 0;
  logic [7:0] tx_data = 0, ext = 0, flip = 0;
  logic       tx_ready, rx_valid, busy, contention_err;
  logic [7:0] rx_data, pad_o, pad_i, pad_t;
  logic       tx_ready3, rx_valid3, busy3, contention_err3;
  logic [7:0] rx_data3, pad_o3, pad_i3, pad_t3;
  int n = 0, bad = 0;
`ifdef PAD_BUS_CONTENTION_CHK_EN
  localparam bit CHK = 1;
`else
  localparam bit CHK = 0;
`endif
  always #5 clk = ~clk;
  assign pad_o  = pad_t[0] ? ext : (pad_i ^ flip);
  assign pad_o3 = pad_t3[0] ? ext : pad_i3;
  pad_bus_ctrl #(.WIDTH(8), .TURN_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready), .rx_en(rx_en), .rx_valid(rx_valid), .rx_data(rx_data),
    .pad_o(pad_o), .pad_i(pad_i), .pad_t(pad_t), .busy(busy), .contention_err(contention_err));
  pad_bus_ctrl #(.WIDTH(8), .TURN_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready3), .rx_en(rx_en), .rx_valid(rx_valid3), .rx_data(rx_data3),
    .pad_o(pad_o3), .pad_i(pad_i3), .pad_t(pad_t3), .busy(busy3), .contention_err(contention_err3));
  typedef struct {
    logic rst, v; logic [7:0] d; logic last, rx; logic [7:0] ext;
    logic t; logic [7:0] pi; logic rdy, busy, rv; logic [7:0] rd;
  } vec_t;
  vec_t vq[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic l);
    rst = r; tx_valid = v; tx_data = d; tx_last = l;
  endtask
  initial begin
    //            rst v  d      last rx ext     t  pi     rdy busy rv rd
    vq.push_back('{1, 0, 8'h00, 0, 0, 8'h00,  1, 8'h00, 1, 0, 0, 8'h00});
    vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00,  1, 8'h00, 1, 0, 0, 8'h00});
    vq.push_back('{0, 1, 8'h11, 0, 0, 8'h00,  0, 8'h11, 1, 1, 0, 8'h00});
    vq.push_back('{0, 1, 8'h22, 0, 0, 8'h00,  0, 8'h22, 1, 1, 0, 8'h00});
    vq.push_back('{0, 1, 8'h33, 1, 0, 8'h00,  0, 8'h33, 0, 1, 0, 8'h00});
    vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00,  1, 8'h33, 0, 1, 0, 8'h00});
    vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00,  1, 8'h33, 1, 0, 0, 8'h00});
    vq.push_back('{0, 1, 8'hA5, 0, 0, 8'h00,  0, 8'hA5, 1, 1, 0, 8'h00});
    vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00,  0, 8'hA5, 1, 1, 0, 8'h00});
    vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00,  0, 8'hA5, 1, 1, 0, 8'h00});
    vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00,  0, 8'hA5, 1, 1, 0, 8'h00});
    vq.push_back('{0, 1, 8'h5A, 1, 0, 8'h00,  0, 8'h5A, 0, 1, 0, 8'h00});
    vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00,  1, 8'h5A, 0, 1, 0, 8'h00});
    vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00,  1, 8'h5A, 1, 0, 0, 8'h00});
    vq.push_back('{0, 0, 8'h00, 0, 1, 8'hC3,  1, 8'h5A, 1, 0, 1, 8'hC3});
    vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00,  1, 8'h5A, 1, 0, 0, 8'hC3});
    vq.push_back('{0, 1, 8'h77, 0, 1, 8'h99,  0, 8'h77, 1, 1, 1, 8'h99});
    vq.push_back('{0, 0, 8'h00, 0, 1, 8'h12,  0, 8'h77, 1, 1, 0, 8'h99});
    vq.push_back('{0, 1, 8'h88, 1, 1, 8'h12,  0, 8'h88, 0, 1, 0, 8'h99});
    vq.push_back('{0, 0, 8'h00, 0, 1, 8'h44,  1, 8'h88, 0, 1, 0, 8'h99});
    vq.push_back('{0, 0, 8'h00, 0, 1, 8'h44,  1, 8'h88, 1, 0, 1, 8'h44});
    vq.push_back('{0, 1, 8'h01, 1, 0, 8'h00,  0, 8'h01, 0, 1, 0, 8'h44});
    vq.push_back('{0, 1, 8'h02, 1, 0, 8'h00,  1, 8'h01, 0, 1, 0, 8'h44});
    vq.push_back('{0, 1, 8'h02, 1, 0, 8'h00,  1, 8'h01, 1, 0, 0, 8'h44});
    vq.push_back('{0, 1, 8'h02, 1, 0, 8'h00,  0, 8'h02, 0, 1, 0, 8'h44});
    vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00,  1, 8'h02, 0, 1, 0, 8'h44});
    vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00,  1, 8'h02, 1, 0, 0, 8'h44});
    vq.push_back('{0, 1, 8'h55, 0, 0, 8'h00,  0, 8'h55, 1, 1, 0, 8'h44});
    vq.push_back('{1, 1, 8'h66, 0, 0, 8'h00,  1, 8'h00, 1, 0, 0, 8'h00});
    vq.push_back('{0, 0, 8'h00, 0, 0, 8'h00,  1, 8'h00, 1, 0, 0, 8'h00});
    #2;
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].v, vq[i].d, vq[i].last);
      rx_en = vq[i].rx;
      ext   = vq[i].ext;
      step();
      chk($sformatf("v%0d pad_t", i), pad_t, {8{vq[i].t}});
      chk($sformatf("v%0d pad_i", i), pad_i, vq[i].pi);
      chk($sformatf("v%0d tx_ready", i), tx_ready, vq[i].rdy);
      chk($sformatf("v%0d busy", i), busy, vq[i].busy);
      chk($sformatf("v%0d rx_valid", i), rx_valid, vq[i].rv);
      chk($sformatf("v%0d rx_data", i), rx_data, vq[i].rd);
      chk($sformatf("v%0d contention_err", i), contention_err, 0);
    end
    rx_en = 0;
    ext   = 0;
    // contention: drive 0x0F while the pin reads back 0x0E
    drive(1, 0, 8'h00, 0); step();
    flip = 8'h01;
    drive(0, 1, 8'h0F, 0); step();
    chk("cont drive pad_t", pad_t, 8'h00);
    drive(0, 0, 8'h00, 0); step();
    chk("cont set", contention_err, CHK);
    drive(0, 1, 8'h0F, 1); step();
    drive(0, 0, 8'h00, 0); step(); step();
    chk("cont released pad_t", pad_t, 8'hFF);
    chk("cont sticky", contention_err, CHK);
    flip = 8'h00;
    drive(1, 0, 8'h00, 0); step();
    chk("cont cleared by rst", contention_err, 0);
    // TURN_CYCLES=3 instance, beat held valid across the turnaround
    drive(0, 1, 8'hAB, 1); step();
    chk("t3 e1 pad_t", pad_t3, 8'h00);
    chk("t3 e1 tx_ready", tx_ready3, 0);
    tx_data = 8'hCD;
    for (int k = 2; k <= 4; k++) begin
      step();
      chk($sformatf("t3 e%0d pad_t", k), pad_t3, 8'hFF);
      chk($sformatf("t3 e%0d tx_ready", k), tx_ready3, 0);
      chk($sformatf("t3 e%0d pad_i", k), pad_i3, 8'hAB);
    end
    step();
    chk("t3 e5 pad_t", pad_t3, 8'hFF);
    chk("t3 e5 tx_ready", tx_ready3, 1);
    chk("t3 e5 busy", busy3, 0);
    step();
    chk("t3 e6 pad_t", pad_t3, 8'h00);
    chk("t3 e6 pad_i", pad_i3, 8'hCD);
    drive(0, 0, 8'h00, 0); step(); step(); step(); step();
    chk("t3 end busy", busy3, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
